// File: rtl/cache_fill_ctrl_if.sv
// cache_fill_ctrl_if: miss, memory and fill-array signals between the fill controller and its neighbours
interface cache_fill_ctrl_if #(parameter int ADDR_W = 16, parameter int DATA_W = 16);
  logic i_miss;
  logic [ADDR_W-1:0] i_miss_addr;
  logic d_miss;
  logic [ADDR_W-1:0] d_miss_addr;
  logic mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic mem_data_valid;
  logic [DATA_W-1:0] mem_data_in;
  logic fill_sel;
  logic fill_data_we;
  logic [2:0] fill_word;
  logic [DATA_W-1:0] fill_data;
  logic [ADDR_W-1:0] fill_tag;
  logic fill_tag_we;
  logic i_fill_done;
  logic d_fill_done;
  logic busy;
  modport master (
    input i_miss, i_miss_addr, d_miss, d_miss_addr, mem_data_valid, mem_data_in,
    output mem_en, mem_addr, fill_sel, fill_data_we, fill_word, fill_data,
    output fill_tag, fill_tag_we, i_fill_done, d_fill_done, busy
  );
  modport slave (
    output i_miss, i_miss_addr, d_miss, d_miss_addr, mem_data_valid, mem_data_in,
    input mem_en, mem_addr, fill_sel, fill_data_we, fill_word, fill_data,
    input fill_tag, fill_tag_we, i_fill_done, d_fill_done, busy
  );
endinterface

// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl: arbitrates I/D misses and streams 8-word block fills from memory into the chosen cache
module cache_fill_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int WORDS = 8
) (
  input logic clk,
  input logic rst,
  cache_fill_ctrl_if.master bus
);
  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, TAG, DONE} state_t;
  localparam logic [ADDR_W-1:0] BLK_MASK = ADDR_W'(WORDS * DATA_W / 8 - 1);
  localparam logic [2:0] LAST = 3'(WORDS - 1);
  state_t state_q, state_d;
  logic [2:0] issue_q, issue_d, recv_q, recv_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic sel_q, sel_d;
  logic we;
  // next-state, counters and grant latching; data writes count valid pulses only
  always_comb begin
    state_d = state_q;
    issue_d = issue_q;
    recv_d = recv_q;
    base_d = base_q;
    sel_d = sel_q;
    we = (state_q == ISSUE || state_q == DRAIN) && bus.mem_data_valid;
    if (we) recv_d = recv_q + 3'd1;
    case (state_q)
      IDLE: if (bus.d_miss || bus.i_miss) begin
        sel_d = bus.d_miss;
        base_d = (bus.d_miss ? bus.d_miss_addr : bus.i_miss_addr) & ~BLK_MASK;
        issue_d = '0;
        recv_d = '0;
        state_d = ISSUE;
      end
      ISSUE: begin
        issue_d = issue_q + 3'd1;
        state_d = (we && recv_q == LAST) ? TAG : (issue_q == LAST ? DRAIN : ISSUE);
      end
      DRAIN: state_d = (we && recv_q == LAST) ? TAG : DRAIN;
      TAG: state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      issue_q <= '0;
      recv_q <= '0;
      base_q <= '0;
      sel_q <= 1'b0;
    end else begin
      state_q <= state_d;
      issue_q <= issue_d;
      recv_q <= recv_d;
      base_q <= base_d;
      sel_q <= sel_d;
    end
  end
  assign bus.mem_en = state_q == ISSUE;
  assign bus.mem_addr = (state_q == ISSUE) ? base_q + ADDR_W'(issue_q) * ADDR_W'(DATA_W / 8) : '0;
  assign bus.fill_sel = sel_q;
  assign bus.fill_data_we = we;
  assign bus.fill_word = recv_q;
  assign bus.fill_data = bus.mem_data_in;
  assign bus.fill_tag = base_q;
  assign bus.fill_tag_we = state_q == TAG;
  assign bus.i_fill_done = state_q == DONE && !sel_q;
  assign bus.d_fill_done = state_q == DONE && sel_q;
  assign bus.busy = state_q != IDLE;
endmodule

// File: doc/cache_fill_ctrl.md
# cache_fill_ctrl

Miss-handling controller that sequences block fills into the instruction and data caches. It arbitrates between a pending I-cache miss and D-cache miss and streams the 8-word block from the pipelined multi-cycle memory into the selected cache's data array. It then writes the tag into the selected metadata array, which updates valid/LRU, and signals completion to the stalled requester. It sits between both caches' data/metadata arrays and the single shared memory port.

## Interface
- ADDR_W, 16, byte address width
- DATA_W, 16, word width (2-byte words)
- WORDS, 8, words per block (16-byte block; word index 3 bits)
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- i_miss  in  1  I-cache miss pending; held until i_fill_done
- i_miss_addr  in  ADDR_W  I-cache miss address
- d_miss  in  1  D-cache miss pending; held until d_fill_done
- d_miss_addr  in  ADDR_W  D-cache miss address
- mem_en  out  1  memory read request this cycle
- mem_addr  out  ADDR_W  memory read address
- mem_data_valid  in  1  one returned word this cycle, in request order
- mem_data_in  in  DATA_W  returned word
- fill_sel  out  1  target cache: 0 = I, 1 = D; stable for whole fill
- fill_data_we  out  1  write fill_data into selected data array
- fill_word  out  3  word index within block for fill_data_we
- fill_data  out  DATA_W  word to write (combinational copy of mem_data_in)
- fill_tag  out  ADDR_W  latched miss address, block-aligned, for tag/set extraction
- fill_tag_we  out  1  write tag into selected metadata array
- i_fill_done  out  1  one-cycle pulse: I fill complete
- d_fill_done  out  1  one-cycle pulse: D fill complete
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, ISSUE, DRAIN, TAG, DONE.
- IDLE: if d_miss, grant D. Else if i_miss, grant I. Fixed priority D > I. On grant:
  - latch base = addr & ~0xF into fill_tag
  - latch fill_sel
  - clear issue_cnt and recv_cnt
  - go to ISSUE
- ISSUE: mem_en=1, mem_addr = base + 2*issue_cnt. issue_cnt increments each cycle. After issue_cnt=7 is issued, go to DRAIN.
- ISSUE/DRAIN: each mem_data_valid produces fill_data_we=1 with fill_word=recv_cnt, then recv_cnt increments. The controller never assumes a fixed latency; it counts valid pulses only.
- When the 8th word is received (recv_cnt=7 with valid), go to TAG. If this happens while still in ISSUE (impossible for latency ≥1), that is a don't-care.
- TAG: fill_tag_we=1 for exactly one cycle, then DONE.
- DONE: pulse i_fill_done or d_fill_done according to fill_sel. Next state is IDLE. No grant is taken in DONE.
- mem_data_valid in IDLE, TAG or DONE is ignored: no fill_data_we, no counter change.
- A miss dropped mid-fill is ignored. The fill completes, and the done pulse is still issued.
- A new miss on the other cache during a fill waits in IDLE arbitration. It is not preempted.
- Counters are 3 bits and saturate-free. Wrap from 7 is never used because the state changes first.

## Timing
- Reset: next edge forces IDLE. All outputs are 0, including mem_addr, fill_tag and fill_sel. Counters are cleared.
- Reset mid-fill behaves the same. Memory words still in flight after reset are ignored. No tag is written, so the partial block stays invalid.
- With grant at edge E0 and memory latency L (valid L cycles after request):
  - ISSUE occupies cycles 1..8.
  - Data writes occur in cycles 1+L..8+L.
  - TAG is at 9+L.
  - DONE is at 10+L.
  - IDLE is at 11+L, which is the earliest next grant.
- L=4 gives a miss penalty of 14 cycles to the done pulse.
- busy rises the cycle after grant and falls when entering IDLE.
- Outputs are Moore-decoded from state, except fill_data_we, fill_word and fill_data, which follow mem_data_valid in the same cycle.

## Test plan
- D miss at 0x1234, L=4:
  - mem_addr = 0x1230, 0x1232, … 0x123E in cycles 1–8
  - fill_data_we with fill_word 0..7 in cycles 5–12
  - fill_tag_we at 13 with fill_tag = 0x1230 and fill_sel = 1
  - d_fill_done pulse at 14; i_fill_done stays 0
- i_miss (0x0040) and d_miss (0x8008) asserted in the same cycle:
  - D fill (base 0x8000) runs first; I fill (base 0x0040) is granted only after DONE→IDLE
  - fill_sel = 0 throughout the second fill
- Irregular latency: valid pulses with gaps (returns at L=4, 5, 7, …):
  - exactly 8 data writes in order 0..7
  - TAG one cycle after the 8th valid; no extra writes
- rst asserted in cycle 6 of a fill:
  - next edge returns all outputs to 0
  - late mem_data_valid pulses produce no fill_data_we
  - fill_tag_we is never asserted
- mem_data_valid asserted while IDLE: no fill_data_we, busy = 0, state stays IDLE.
- i_miss deasserted mid-fill: the fill completes, and the i_fill_done pulse still appears at cycle 14.
